// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants and FSM encoding for the FIFO-drain UART transmitter.
package fifo_uart_tx_pkg;

    // Default FIFO word width and 100 MHz / 115200 baud divider.
    localparam int FIFO_BIT_DEPTH    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    // 3-bit state encoding, shared with the future RX stage's debug taps.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running bit-period counter, held at zero while cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it as 8N1 UART, LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int BIT_DEPTH    = FIFO_BIT_DEPTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    input  logic [BIT_DEPTH-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                IDX_W    = $clog2(BIT_DEPTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BIT_DEPTH - 1);
    // frame_done is registered, so it is armed one cycle before the stop bit ends.
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_e            state_q;
    logic [BIT_DEPTH-1:0] shift_q;
    logic [BIT_DEPTH-1:0] shift_nxt;
    logic [IDX_W-1:0]     idx_q;
    logic                 tx_q;
    logic                 rd_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;
    logic                 baud_clr;
    logic [CNT_W-1:0]     baud_cnt;

    // Bit timing only runs while a bit is on the line; LOAD leaves it at zero.
    assign baud_clr  = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);
    assign shift_nxt = shift_q >> 1;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (baud_clr),
        .tick_o (tick),
        .cnt_o  (baud_cnt)
    );

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_enable && !fifo_empty) begin
                        state_q <= ST_POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_POP: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // FIFO read data is valid the cycle after the pop strobe.
                    shift_q <= fifo_data;
                    idx_q   <= '0;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_nxt;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            tx_q <= shift_nxt[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == PRE_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the MyFIFO buffer on the Arty-7.
- Pops one word at a time from the FIFO via its enable_read strobe and serialises it as 8N1 UART (LSB first) on the board's USB-UART TX pin.
- Runs continuously while the FIFO is non-empty and tx_enable is high. Back-pressure is inherent: no pop occurs until the previous frame's stop bit completes.

Parameters:
- BIT_DEPTH, 8, data word width; must equal the FIFO's `BIT_DEPTH.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Minimum 2.
- CNT_W, 10, width of the baud counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_enable  in  1  permits starting a new frame; a frame in flight always completes.
- fifo_empty  in  1  FIFO empty flag; pop permitted only when 0.
- fifo_data  in  BIT_DEPTH  FIFO read data (value_to_read), valid the cycle after enable_read.
- fifo_rd_en  out  1  one-cycle pop strobe to the FIFO's enable_read.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from pop strobe until the end of the stop bit.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge), effective the same edge, including mid-frame:
  - State = IDLE; tx=1, fifo_rd_en=0, busy=0, frame_done=0; counters and shift register cleared.
  - A partially sent frame is abandoned. The line returns high immediately.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE:
  - If tx_enable=1 and fifo_empty=0, go to POP.
  - tx=1, busy=0.
- POP (one cycle):
  - fifo_rd_en=1, busy=1. Next state is LOAD.
- LOAD (one cycle):
  - Capture fifo_data into the shift register; clear the baud counter and bit index. Next state is START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit; then shift right and increment the bit index.
  - After BIT_DEPTH bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles; frame_done=1 on the final cycle.
  - Then go to IDLE. busy drops when the state is IDLE.
- Latency:
  - IDLE-detect to the first start-bit cycle is 3 clk: IDLE -> POP -> LOAD -> START.
  - The frame lasts (BIT_DEPTH+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames have 3 idle-high cycles between the stop bit and the next start bit (IDLE, POP, LOAD).
- tx is registered, with no combinational path from inputs to tx.
- fifo_rd_en is asserted only in POP. It is never asserted while fifo_empty=1 was sampled in IDLE, so the FIFO cannot underflow.
- fifo_empty and tx_enable are ignored outside IDLE. Dropping tx_enable mid-frame does not truncate the frame.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- The bit index is $clog2(BIT_DEPTH+1) wide.

Decomposition:
- Shared defines header, the existing one holding `BIT_DEPTH/`FIFO_VOLUME, gains:
  - `UART_CLKS_PER_BIT
  - state encodings as `define constants (3-bit)
- Sub-module uart_baud_tick:
  - Counter with a clear input and a one-cycle tick output every CLKS_PER_BIT cycles.
  - Reused later by the RX stage.

Test Plan (CLKS_PER_BIT=4, BIT_DEPTH=8):
1. Reset, then fifo_empty=1 and tx_enable=1 for 50 cycles -> tx stays 1; fifo_rd_en, busy and frame_done are never 1.
2. fifo_empty=0, fifo_data=8'hA5 after the pop -> fifo_rd_en pulses exactly 1 cycle; tx bits sampled mid-bit are 0,1,0,1,0,0,1,0,1,1. The frame spans 40 cycles; frame_done pulses once, on cycle 40.
3. FIFO model holding 8'h07 then 8'h0C -> two pops; tx carries 07 then 0C. Between stop bit 1 and start bit 2, tx is high for exactly 3 cycles.
4. tx_enable deasserted during DATA of an 8'h3C frame -> the frame completes intact; no further pop occurs while tx_enable=0 even with fifo_empty=0.
5. rst asserted for 1 cycle during bit 4 of 8'hFF -> the next cycle has tx=1, busy=0; the next frame starts cleanly with a full start bit.
6. fifo_empty toggling every cycle in IDLE with tx_enable=1 -> every pop coincides with fifo_empty=0 sampled the previous cycle; the model's underflow counter stays 0.
